// File: rtl/dff_pipe_pkg.sv
// rtl/dff_pipe_pkg.sv - shared constants and helpers for the dff_pipe register pipeline
package dff_pipe_pkg;

  localparam int RST_VAL_DEFAULT = 0;

  // Width needed to hold an occupancy value in 0..depth inclusive.
  function automatic int clog2p1(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one valid/data register pair of the dff_pipe pipeline
module dff_pipe_stage #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic             v_q;
  logic [WIDTH-1:0] d_q;

  // Data of an invalid stage is held so a bubble never toggles the data bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= 1'b0;
      d_q <= RST_VAL;
    end else if (clr) begin
      v_q <= 1'b0;
      d_q <= RST_VAL;
    end else if (load) begin
      v_q <= src_valid;
      if (src_valid) d_q <= src_data;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - stallable bubble-collapsing register pipeline; DFF_PIPE_COUNT_EN adds an occupancy count port
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_COUNT_EN
  ,
  output logic [clog2p1(DEPTH)-1:0] count
`endif
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             rdy_acc;
  logic             in_fire;

  // rdy[k] is true when any stage at or after k is empty, or the consumer takes the head.
  always_comb begin
    rdy_acc = out_ready;
    rdy     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_acc = rdy_acc || !v[k];
      rdy[k]  = rdy_acc;
    end
  end

  assign in_ready = rdy[0] && !clr;
  assign in_fire  = in_valid && in_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (rdy[k]),
        .src_valid (in_fire),
        .src_data  (in_data),
        .v         (v[k]),
        .d         (d[k])
      );
    end else begin : g_body
      dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (rdy[k]),
        .src_valid (v[k-1]),
        .src_data  (d[k-1]),
        .v         (v[k]),
        .d         (d[k])
      );
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef DFF_PIPE_COUNT_EN
  localparam int CW = clog2p1(DEPTH);

  logic          out_fire;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign out_fire = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (clr)                       count_d = '0;
    else if (in_fire && !out_fire) count_d = count_q + 1'b1;
    else if (out_fire && !in_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4, RST_VAL=0)
module tb_dff_pipe;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef DFF_PIPE_COUNT_EN
  logic [2:0] count;
  int         cnt_m;
`endif

  logic [7:0] exp_q [$];
  int         n_checks;
  int         n_errors;
  int         n_in;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DFF_PIPE_COUNT_EN
    ,
    .count     (count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  // Inputs are set just after a negedge; this samples 1 time unit later, then advances one full clock.
  task automatic cycle();
    logic       in_f;
    logic       out_f;
    logic [7:0] e;
    #1;
    in_f  = in_valid && in_ready;
    out_f = out_valid && out_ready;
    if (out_f) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_data", {24'd0, out_data}, {24'd0, e});
      end
    end
    if (in_f) begin
      exp_q.push_back(in_data);
      n_in++;
    end
`ifdef DFF_PIPE_COUNT_EN
    if (clr) cnt_m = 0;
    else if (in_f && !out_f) cnt_m++;
    else if (out_f && !in_f) cnt_m--;
`endif
    @(posedge clk);
    @(negedge clk);
`ifdef DFF_PIPE_COUNT_EN
    check("count_track", {29'd0, count}, cnt_m);
`endif
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_in     = 0;
`ifdef DFF_PIPE_COUNT_EN
    cnt_m    = 0;
`endif
    rst       = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'h00);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DFF_PIPE_COUNT_EN
    check("rst_count", {29'd0, count}, 32'd0);
`endif

    // Latency: first word visible after the 4th edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11; cycle();
    check("lat_edge1", {31'd0, out_valid}, 32'd0);
    in_data   = 8'h22; cycle();
    check("lat_edge2", {31'd0, out_valid}, 32'd0);
    in_data   = 8'h33; cycle();
    check("lat_edge3", {31'd0, out_valid}, 32'd0);
    in_valid  = 1'b0;  cycle();
    check("lat_edge4_valid", {31'd0, out_valid}, 32'd1);
    check("lat_edge4_data", {24'd0, out_data}, 32'h11);
    cycle();
    check("lat_next_data", {24'd0, out_data}, 32'h22);
    drain();

    // Backpressure: six words offered, only four fit.
    out_ready = 1'b0;
    n_in      = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(n_in);
      cycle();
    end
    check("bp_accepted", n_in, 32'd4);
    #1;
    check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
`ifdef DFF_PIPE_COUNT_EN
    check("bp_count", {29'd0, count}, 32'd4);
`endif
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_recover", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 20 && n_in < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(n_in);
      cycle();
    end
    check("bp_all_accepted", n_in, 32'd6);
    drain();

    // Bubble collapse: stage3=W1, stage2 empty, stage1=W2, output stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB1; cycle();
    in_valid = 1'b0;                  cycle();
    in_valid = 1'b1; in_data = 8'hB2; cycle();
    in_valid = 1'b0;                  cycle();
    check("bub_out_valid", {31'd0, out_valid}, 32'd1);
    check("bub_head", {24'd0, out_data}, 32'hB1);
    check("bub_in_ready_before", {31'd0, in_ready}, 32'd1);
    cycle();
    check("bub_in_ready_after", {31'd0, in_ready}, 32'd1);
    n_in = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hB3 + 8'(n_in);
      cycle();
    end
    check("bub_extra_accepted", n_in, 32'd2);
    drain();

    // Clear of a full pipeline, with a head transfer in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      cycle();
    end
    clr       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    #1;
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    exp_q.delete();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_out_data", {24'd0, out_data}, 32'h00);
    for (int i = 0; i < 4; i++) cycle();
    check("clr_stays_empty", {31'd0, out_valid}, 32'd0);

    // Simultaneous input and output fire keeps occupancy at two.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hD1; cycle();
    in_valid = 1'b1; in_data = 8'hD2; cycle();
    in_valid = 1'b0; cycle(); cycle();
    check("sim_head_valid", {31'd0, out_valid}, 32'd1);
`ifdef DFF_PIPE_COUNT_EN
    check("sim_count_before", {29'd0, count}, 32'd2);
`endif
    in_valid  = 1'b1;
    in_data   = 8'hD3;
    out_ready = 1'b1;
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef DFF_PIPE_COUNT_EN
    check("sim_count_after", {29'd0, count}, 32'd2);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
